// File: rtl/reg_bank_4x16.sv
// reg_bank_4x16: four-register datapath bank (R0-R3) with single-cycle
// LOAD/MOVE/INC/DEC/ADD/CLR/SWAP ops and registered carry/zero flags.
// R0-R3 are exposed directly on a-d so a downstream source mux can tap them.
module reg_bank_4x16 #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [1:0]       dst,
    input  logic [1:0]       src,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_MOVE = 3'b010,
        OP_INC  = 3'b011,
        OP_DEC  = 3'b100,
        OP_ADD  = 3'b101,
        OP_CLR  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs     [4];
    logic [WIDTH-1:0] nxt_regs [4];
    logic             nxt_carry;
    logic             nxt_zero;
    logic [WIDTH-1:0] rd_dst;
    logic [WIDTH-1:0] rd_src;
    logic [WIDTH:0]   add_res;
    logic [WIDTH:0]   sub_res;
    op_e              opc;

    assign opc = op_e'(op);

    // Next-state datapath: all operands come from pre-edge register values,
    // so SWAP and src==dst cases fall out without special handling.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            nxt_regs[i] = regs[i];
        end
        nxt_carry = carry;
        nxt_zero  = zero;
        rd_dst    = regs[dst];
        rd_src    = regs[src];
        add_res   = {1'b0, rd_dst} + {1'b0, (opc == OP_ADD) ? rd_src : WIDTH'(1)};
        sub_res   = {1'b0, rd_dst} - {{WIDTH{1'b0}}, 1'b1};
        case (opc)
            OP_LOAD: begin
                nxt_regs[dst] = din;
                nxt_zero      = (din == '0);
            end
            OP_MOVE: begin
                nxt_regs[dst] = rd_src;
                nxt_zero      = (rd_src == '0);
            end
            OP_INC, OP_ADD: begin
                nxt_regs[dst] = add_res[WIDTH-1:0];
                nxt_carry     = add_res[WIDTH];
                nxt_zero      = (add_res[WIDTH-1:0] == '0);
            end
            OP_DEC: begin
                nxt_regs[dst] = sub_res[WIDTH-1:0];
                nxt_carry     = sub_res[WIDTH];
                nxt_zero      = (sub_res[WIDTH-1:0] == '0);
            end
            OP_CLR: begin
                nxt_regs[dst] = '0;
                nxt_zero      = 1'b1;
            end
            OP_SWAP: begin
                nxt_regs[dst] = rd_src;
                nxt_regs[src] = rd_dst;
            end
            default: ;
        endcase
    end

    // State registers: synchronous reset overrides any op on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= RESET_VAL;
            end
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= nxt_regs[i];
            end
            carry <= nxt_carry;
            zero  <= nxt_zero;
        end
    end

    assign a = regs[0];
    assign b = regs[1];
    assign c = regs[2];
    assign d = regs[3];

endmodule

// File: tb/tb_reg_bank_4x16.sv
// Directed, table-driven bench for reg_bank_4x16 plus a downstream 4:1 mux.
module tb_reg_bank_4x16;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] MOVE = 3'b010;
    localparam logic [2:0] INC  = 3'b011;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] ADD  = 3'b101;
    localparam logic [2:0] CLR  = 3'b110;
    localparam logic [2:0] SWAP = 3'b111;

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [15:0] din;
        logic [15:0] ea, eb, ec, ed;
        logic        ecarry, ezero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [1:0]  dst, src;
    logic [15:0] din;
    logic [15:0] a, b, c, d;
    logic        carry, zero;
    logic [1:0]  sel;
    logic [15:0] mux_out;

    int checks = 0;
    int errors = 0;

    vec_t tbl [26];

    reg_bank_4x16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst), .op(op), .dst(dst), .src(src), .din(din),
        .a(a), .b(b), .c(c), .d(d), .carry(carry), .zero(zero)
    );

    // Downstream source mux fed by the register views
    always_comb begin
        case (sel)
            2'd0:    mux_out = a;
            2'd1:    mux_out = b;
            2'd2:    mux_out = c;
            default: mux_out = d;
        endcase
    end

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] o, input logic [1:0] ds,
                                input logic [1:0] sr, input logic [15:0] dn,
                                input logic [15:0] xa, input logic [15:0] xb,
                                input logic [15:0] xc, input logic [15:0] xd,
                                input logic xcy, input logic xz);
        vec_t v;
        v.rst = r; v.op = o; v.dst = ds; v.src = sr; v.din = dn;
        v.ea = xa; v.eb = xb; v.ec = xc; v.ed = xd; v.ecarry = xcy; v.ezero = xz;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [2:0] o, input logic [1:0] ds,
                         input logic [1:0] sr, input logic [15:0] dn);
        @(negedge clk);
        rst = r; op = o; dst = ds; src = sr; din = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [15:0] xa, input logic [15:0] xb,
                               input logic [15:0] xc, input logic [15:0] xd,
                               input logic xcy, input logic xz);
        checks++;
        if ({a, b, c, d, carry, zero} !== {xa, xb, xc, xd, xcy, xz}) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h c=%h d=%h carry=%b zero=%b, want a=%h b=%h c=%h d=%h carry=%b zero=%b",
                     name, a, b, c, d, carry, zero, xa, xb, xc, xd, xcy, xz);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; op = NOP; dst = '0; src = '0; din = '0; sel = '0;

        //             rst op    dst src din       a        b        c        d      cy zr
        tbl[0]  = mk(1, LOAD, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = mk(0, LOAD, 2, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 0);
        tbl[2]  = mk(0, INC,  2, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1);
        tbl[3]  = mk(0, DEC,  2, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1, 0);
        tbl[4]  = mk(0, LOAD, 0, 0, 16'h8001, 16'h8001, 16'h0000, 16'hFFFF, 16'h0000, 1, 0);
        tbl[5]  = mk(0, LOAD, 1, 0, 16'h8000, 16'h8001, 16'h8000, 16'hFFFF, 16'h0000, 1, 0);
        tbl[6]  = mk(0, ADD,  0, 1, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 1, 0);
        tbl[7]  = mk(0, ADD,  1, 1, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1, 1);
        tbl[8]  = mk(0, NOP,  3, 2, 16'h7777, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1, 1);
        tbl[9]  = mk(0, LOAD, 1, 0, 16'h1234, 16'h0001, 16'h1234, 16'hFFFF, 16'h0000, 1, 0);
        tbl[10] = mk(0, LOAD, 3, 0, 16'hABCD, 16'h0001, 16'h1234, 16'hFFFF, 16'hABCD, 1, 0);
        tbl[11] = mk(0, CLR,  0, 0, 16'h0000, 16'h0000, 16'h1234, 16'hFFFF, 16'hABCD, 1, 1);
        tbl[12] = mk(0, SWAP, 1, 3, 16'h0000, 16'h0000, 16'hABCD, 16'hFFFF, 16'h1234, 1, 1);
        tbl[13] = mk(0, MOVE, 0, 3, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h1234, 1, 0);
        tbl[14] = mk(0, DEC,  0, 0, 16'h0000, 16'h1233, 16'hABCD, 16'hFFFF, 16'h1234, 0, 0);
        tbl[15] = mk(0, INC,  0, 0, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h1234, 0, 0);
        tbl[16] = mk(0, SWAP, 2, 2, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h1234, 0, 0);
        tbl[17] = mk(0, CLR,  3, 0, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h0000, 0, 1);
        tbl[18] = mk(0, MOVE, 2, 2, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h0000, 0, 0);
        tbl[19] = mk(0, ADD,  2, 2, 16'h0000, 16'h1234, 16'hABCD, 16'hFFFE, 16'h0000, 1, 0);
        tbl[20] = mk(1, LOAD, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        tbl[21] = mk(0, LOAD, 0, 0, 16'h5555, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        tbl[22] = mk(0, DEC,  1, 0, 16'h0000, 16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 1, 0);
        tbl[23] = mk(0, ADD,  2, 3, 16'h0000, 16'h5555, 16'hFFFF, 16'h0000, 16'h0000, 0, 1);
        tbl[24] = mk(0, SWAP, 0, 1, 16'h0000, 16'hFFFF, 16'h5555, 16'h0000, 16'h0000, 0, 1);
        tbl[25] = mk(0, MOVE, 3, 0, 16'h0000, 16'hFFFF, 16'h5555, 16'h0000, 16'hFFFF, 0, 0);

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].din);
            check_state($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed,
                        tbl[i].ecarry, tbl[i].ezero);
        end

        // Outputs must not follow inputs between edges
        @(negedge clk);
        op = LOAD; dst = 2'd0; din = 16'h0F0F;
        #2;
        check16("no_comb_path", a, 16'hFFFF);

        // Mux integration: load R0-R3 then walk the select
        drive(0, LOAD, 0, 0, 16'h1111);
        drive(0, LOAD, 1, 0, 16'h2222);
        drive(0, LOAD, 2, 0, 16'h3333);
        drive(0, LOAD, 3, 0, 16'h4444);
        drive(0, NOP, 0, 0, 16'h0000);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check16($sformatf("mux_sel%0d", s), mux_out, 16'(16'h1111 * (s + 1)));
        end

        // Reset held for several edges with ops pending, then first op right after release
        drive(1, INC, 1, 0, 16'h0000);
        drive(1, ADD, 2, 3, 16'h0000);
        check_state("rst_hold", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        drive(0, DEC, 3, 0, 16'h0000);
        check_state("first_after_rst", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_bank_4x16.md
REG_BANK_4X16 -- requirements
Module: reg_bank_4x16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the register and data width in bits.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the value loaded into every register on reset.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port op SHALL be input, 3 bits: operation code, sampled every rising edge.
REQ-006 Port dst SHALL be input, 2 bits: destination register index R0-R3.
REQ-007 Port src SHALL be input, 2 bits: source register index R0-R3.
REQ-008 Port din SHALL be input, WIDTH bits: external load data.
REQ-009 Ports a, b, c, d SHALL be outputs, WIDTH bits each: direct registered views of R0, R1, R2, R3, wired straight into the 4:1 16-bit source mux.
REQ-010 Port carry SHALL be output, 1 bit: registered carry/borrow flag.
REQ-011 Port zero SHALL be output, 1 bit: registered zero flag.

Function
REQ-012 The block SHALL hold four WIDTH-bit registers R0-R3; a, b, c and d SHALL carry no combinational path from any input.
REQ-013 Every operation SHALL complete in one cycle; a result SHALL be visible on a-d and flags immediately after the rising edge on which op is sampled.
REQ-014 Op codes SHALL be: 000 NOP; 001 LOAD R[dst]<=din; 010 MOVE R[dst]<=R[src]; 011 INC R[dst]<=R[dst]+1; 100 DEC R[dst]<=R[dst]-1; 101 ADD R[dst]<=R[dst]+R[src]; 110 CLR R[dst]<=0; 111 SWAP R[dst]<->R[src].
REQ-015 Arithmetic SHALL be modulo 2^WIDTH: INC of all-ones gives 0; DEC of 0 gives all-ones; ADD wraps.
REQ-016 Carry SHALL be set to the carry out of INC and ADD, to the borrow out of DEC (1 only when DEC is applied to 0), and SHALL hold for every other op.
REQ-017 Zero SHALL be set to (new R[dst]==0) for LOAD, MOVE, INC, DEC, ADD and CLR, and SHALL hold for NOP and SWAP.
REQ-018 Source operands SHALL be read from pre-edge register values; ADD with src==dst SHALL compute 2*R[dst].
REQ-019 MOVE with src==dst SHALL leave the register unchanged and SHALL still update zero.
REQ-020 SWAP with src==dst SHALL leave all registers unchanged.
REQ-021 SWAP SHALL exchange both registers on the same edge, using pre-edge values for both.
REQ-022 Registers not named by dst (or by src for SWAP) SHALL hold.
REQ-023 op, dst, src and din SHALL be don't-care while rst is high.

Reset
REQ-024 While rst is high at a rising edge, R0-R3 SHALL load RESET_VAL, and carry and zero SHALL load 0, overriding any op.
REQ-025 Reset asserted on the same edge as any op SHALL win; the op SHALL have no effect.
REQ-026 The first op after rst deasserts SHALL execute on the first rising edge with rst low.

Verification
REQ-027 Reset: any op pending, rst=1 for one edge -> a=b=c=d=0x0000, carry=0, zero=0.
REQ-028 Load/wrap: LOAD R2<=0xFFFF, then INC R2 -> c=0x0000, carry=1, zero=1; then DEC R2 -> c=0xFFFF, carry=1, zero=0.
REQ-029 ADD: R0=0x8001, R1=0x8000, ADD dst=0 src=1 -> a=0x0001, carry=1, zero=0, b unchanged; then ADD dst=1 src=1 -> b=0x0000, carry=1, zero=1.
REQ-030 SWAP/MOVE: R1=0x1234, R3=0xABCD, SWAP dst=1 src=3 -> b=0xABCD, d=0x1234, flags held; then MOVE dst=0 src=3 -> a=0x1234, zero=0.
REQ-031 Reset mid-sequence: LOAD R0<=0x5555 with rst=1 on the same edge -> a=0x0000; next edge LOAD R0<=0x5555 with rst=0 -> a=0x5555.
REQ-032 Mux integration: drive sel=0..3 on the downstream 4:1 mux after loading R0-R3 with 0x1111, 0x2222, 0x3333, 0x4444 -> mux out follows 0x1111, 0x2222, 0x3333, 0x4444.
